// File: rtl/hmac_msg_sequencer_pkg.sv
// Shared constants for the HMAC-384 message sequencer: FSM encodings, block
// geometry, padding byte and the length-field helper.
package hmac_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int         BLOCK_WORDS = 32;
    localparam int         LEN_WORD0   = 28;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    // Bit length of the message plus the offset for blocks already hashed.
    function automatic logic [127:0] len_field(input logic [127:0] nbytes,
                                               input logic [127:0] ofs);
        return (nbytes << 3) + ofs;
    endfunction

endpackage

// File: rtl/hmac_msg_sequencer_if.sv
// Word-stream interface from the message source into the sequencer.
// valid/ready: a word transfers on a rising clk edge where msg_valid_i and
// msg_ready_o are both high; the source holds data/last/bytes stable until then.
interface hmac_msg_sequencer_if;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [31:0] msg_data_i;
    logic        msg_last_i;
    logic [2:0]  msg_bytes_i;

    modport master (output msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i,
                    input  msg_ready_o);
    modport slave  (input  msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i,
                    output msg_ready_o);
endinterface

// File: rtl/hmac_msg_sequencer_pad.sv
// Final-word formatter: keeps the first nbytes bytes (big-endian), places the
// 0x80 pad byte right after them and zeroes the rest.
module hmac_pad_word
    import hmac_seq_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] word_o
);
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes_i) begin
                word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
            end else if (3'(b) == nbytes_i) begin
                word_o[31-8*b -: 8] = PAD_BYTE;
            end
        end
    end
endmodule

// File: rtl/hmac_msg_sequencer.sv
// Packs a 32-bit word stream into 1024-bit SHA-384 blocks with padding and
// length, and sequences init/next commands to hmac_core.
module hmac_msg_sequencer
    import hmac_seq_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int LEN_OFS = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_i,
    hmac_msg_sequencer_if.slave msg_if,
    output logic                core_init_o,
    output logic                core_next_o,
    output logic [1023:0]       core_block_o,
    input  logic                core_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [2:0]          state_o
);
    localparam int SUM_W = CNT_W + 1;

    logic [2:0]        state_q, state_d;
    logic [0:31][31:0] buf_q, buf_d;
    logic [4:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_q, first_d, final_q, final_d;
    logic              pad_pend_q, pad_pend_d, marker_q, marker_d;
    logic              error_q, error_d, wait1_q, wait1_d;

    logic [31:0]       pad_word;
    logic [CNT_W:0]    cnt_sum;
    logic [5:0]        mark_pos;
    logic              full_last, bad_bytes;
    logic [127:0]      len_fill, len_wait;

    hmac_pad_word u_pad (
        .data_i  (msg_if.msg_data_i),
        .nbytes_i(msg_if.msg_bytes_i),
        .word_o  (pad_word)
    );

    assign full_last = msg_if.msg_last_i && (msg_if.msg_bytes_i == 3'd4);
    assign bad_bytes = msg_if.msg_last_i && (msg_if.msg_bytes_i > 3'd4);
    assign cnt_sum   = {1'b0, cnt_q} + (msg_if.msg_last_i ? SUM_W'(msg_if.msg_bytes_i) : SUM_W'(4));
    // Word that receives 0x80: the next one when the last word is full.
    assign mark_pos  = {1'b0, idx_q} + (full_last ? 6'd1 : 6'd0);
    assign len_fill  = len_field(128'(cnt_sum[CNT_W-1:0]), 128'(LEN_OFS));
    assign len_wait  = len_field(128'(cnt_q), 128'(LEN_OFS));

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        final_d    = final_q;
        pad_pend_d = pad_pend_q;
        marker_d   = marker_q;
        error_d    = error_q;
        wait1_d    = wait1_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d    = ST_FILL;
                buf_d      = '0;
                idx_d      = '0;
                cnt_d      = '0;
                error_d    = 1'b0;
                first_d    = 1'b1;
                final_d    = 1'b0;
                pad_pend_d = 1'b0;
                marker_d   = 1'b0;
            end
            ST_FILL: if (msg_if.msg_valid_i) begin
                if (bad_bytes || cnt_sum[CNT_W]) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d        = cnt_sum[CNT_W-1:0];
                    buf_d[idx_q] = msg_if.msg_last_i ? pad_word : msg_if.msg_data_i;
                    if (!msg_if.msg_last_i) begin
                        if (idx_q == 5'(BLOCK_WORDS-1)) begin
                            state_d    = ST_ISSUE;
                            final_d    = 1'b0;
                            pad_pend_d = 1'b0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end else begin
                        if (full_last && idx_q != 5'(BLOCK_WORDS-1)) begin
                            buf_d[idx_q + 5'd1] = {PAD_BYTE, 24'h0};
                        end
                        // Length fits only if the pad byte sits before the length words.
                        if (mark_pos <= 6'(LEN_WORD0-1)) begin
                            buf_d[LEN_WORD0 +: 4] = len_fill;
                            final_d               = 1'b1;
                            pad_pend_d            = 1'b0;
                        end else begin
                            final_d    = 1'b0;
                            pad_pend_d = 1'b1;
                            marker_d   = (mark_pos == 6'(BLOCK_WORDS));
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                first_d = 1'b0;
                wait1_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (wait1_q) begin
                wait1_d = 1'b0;
            end else if (core_ready_i) begin
                if (final_q) begin
                    state_d = ST_DONE;
                end else if (pad_pend_q) begin
                    buf_d = '0;
                    if (marker_q) buf_d[0] = {PAD_BYTE, 24'h0};
                    buf_d[LEN_WORD0 +: 4] = len_wait;
                    final_d    = 1'b1;
                    pad_pend_d = 1'b0;
                    marker_d   = 1'b0;
                    state_d    = ST_ISSUE;
                end else begin
                    buf_d   = '0;
                    idx_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            final_q    <= 1'b0;
            pad_pend_q <= 1'b0;
            marker_q   <= 1'b0;
            error_q    <= 1'b0;
            wait1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            final_q    <= final_d;
            pad_pend_q <= pad_pend_d;
            marker_q   <= marker_d;
            error_q    <= error_d;
            wait1_q    <= wait1_d;
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    assign msg_if.msg_ready_o = (state_q == ST_FILL);
    assign core_init_o        = (state_q == ST_ISSUE) && first_q;
    assign core_next_o        = (state_q == ST_ISSUE) && !first_q;
    assign core_block_o       = buf_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_DONE);
    assign error_o            = error_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_hmac_msg_sequencer.sv
// Directed bench for hmac_msg_sequencer: a byte-level SHA-384 padding model
// fills the expected block queue, a simple core model answers commands.
module tb_hmac_msg_sequencer;
    import hmac_seq_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic          core_init_o, core_next_o, core_ready_i;
    logic [1023:0] core_block_o;
    logic          busy_o, done_o, error_o;
    logic [2:0]    state_o;

    hmac_msg_sequencer_if msg_if ();

    hmac_msg_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .msg_if      (msg_if),
        .core_init_o (core_init_o),
        .core_next_o (core_next_o),
        .core_block_o(core_block_o),
        .core_ready_i(core_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            passed = 0;
    logic [31:0]   msg_words [64];
    logic [1023:0] exp_q [$];
    logic [1023:0] blk_q [$];
    logic          kind_q [$];
    int            done_cnt = 0, both_viol = 0, ready_viol = 0, stab_viol = 0;
    int            wait_valid_cycles = 0;
    int            core_lat = 3;
    int            lat = 0;

    // ---------------- core model and monitor ----------------
    initial begin
        core_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (core_init_o && core_next_o) both_viol++;
            if (state_o == ST_WAIT && blk_q.size() > 0 && core_block_o !== blk_q[$]) stab_viol++;
            if (state_o == ST_WAIT && msg_if.msg_valid_i) begin
                wait_valid_cycles++;
                if (msg_if.msg_ready_o) ready_viol++;
            end
            if (done_o) done_cnt++;
            if (core_init_o || core_next_o) begin
                kind_q.push_back(core_init_o);
                blk_q.push_back(core_block_o);
                core_ready_i = 1'b0;
                lat = core_lat;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) core_ready_i = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] word_of(input logic [1023:0] b, input int i);
        return b[1023-32*i -: 32];
    endfunction

    function automatic logic [1023:0] blk_at(input int i);
        if (i < blk_q.size()) return blk_q[i];
        return 'x;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_blk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int bad;
        bad = 0;
        for (int i = 31; i >= 0; i--) if (word_of(obs, i) !== word_of(exp, i)) bad = i;
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: word %0d observed %h expected %h", tag, bad,
                    word_of(obs, bad), word_of(exp, bad));
    endtask

    // Standard SHA-384 padding over the byte stream, length offset by 1024 bits.
    task automatic build_expected(input int nwords, input int last_bytes);
        logic [7:0]    bq [$];
        logic [127:0]  bits;
        logic [1023:0] blk;
        int            total, nb;
        exp_q.delete();
        for (int i = 0; i < nwords; i++) begin
            nb = (i == nwords - 1) ? last_bytes : 4;
            for (int b = 0; b < nb; b++) bq.push_back(msg_words[i][31-8*b -: 8]);
        end
        total = bq.size();
        bq.push_back(8'h80);
        while (bq.size() % 128 != 112) bq.push_back(8'h00);
        bits = 128'(total) * 128'd8 + 128'd1024;
        for (int k = 15; k >= 0; k--) bq.push_back(bits[8*k +: 8]);
        for (int n = 0; n < bq.size() / 128; n++) begin
            for (int j = 0; j < 128; j++) blk[1023-8*j -: 8] = bq[128*n + j];
            exp_q.push_back(blk);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_capture();
        kind_q.delete();
        blk_q.delete();
        done_cnt = 0;
    endtask

    task automatic send_msg(input int nwords, input logic [2:0] last_bytes);
        int g, acc;
        acc = 0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            msg_if.msg_valid_i = 1'b1;
            msg_if.msg_data_i  = msg_words[i];
            msg_if.msg_last_i  = (i == nwords - 1);
            msg_if.msg_bytes_i = (i == nwords - 1) ? last_bytes : 3'd4;
            g = 0;
            while (!msg_if.msg_ready_o && g < 300) begin
                @(negedge clk);
                g++;
            end
            if (g >= 300) break;
            acc++;
            @(negedge clk);
        end
        msg_if.msg_valid_i = 1'b0;
        msg_if.msg_last_i  = 1'b0;
        check("accepted_words", 128'(acc), 128'(nwords));
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (state_o != ST_IDLE && g < 500) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_idle_in_time"}, 128'(g < 500), 128'(1));
    endtask

    task automatic run_msg(input string tag, input int nwords, input int last_bytes);
        clear_capture();
        build_expected(nwords, last_bytes);
        send_msg(nwords, 3'(last_bytes));
        wait_idle(tag);
        check({tag, "_nblk"}, 128'(blk_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < blk_q.size() && i < exp_q.size(); i++) begin
            check_blk($sformatf("%s_blk%0d", tag, i), blk_q[i], exp_q[i]);
            check($sformatf("%s_init%0d", tag, i), 128'(kind_q[i]), 128'(i == 0));
        end
        check({tag, "_done"}, 128'(done_cnt), 128'(1));
        check({tag, "_err"}, 128'(error_o), 128'(0));
    endtask

    task automatic abc_msg(input string tag);
        logic [31:0] mid_or;
        msg_words[0] = 32'h61626300;
        run_msg(tag, 1, 3);
        mid_or = '0;
        for (int i = 1; i <= 30; i++) mid_or |= word_of(blk_at(0), i);
        check({tag, "_w0"}, 128'(word_of(blk_at(0), 0)), 128'(32'h61626380));
        check({tag, "_w1_30"}, 128'(mid_or), 128'(0));
        check({tag, "_w31"}, 128'(word_of(blk_at(0), 31)), 128'(32'h00000418));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] acc_or;
        int          g;
        reset_n            = 1'b0;
        start_i            = 1'b0;
        msg_if.msg_valid_i = 1'b0;
        msg_if.msg_data_i  = '0;
        msg_if.msg_last_i  = 1'b0;
        msg_if.msg_bytes_i = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_init", 128'(core_init_o), 128'(0));
        check("rst_next", 128'(core_next_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_err", 128'(error_o), 128'(0));
        check("rst_ready", 128'(msg_if.msg_ready_o), 128'(0));
        check("rst_state", 128'(state_o), 128'(ST_IDLE));
        check_blk("rst_block", core_block_o, '0);

        // 1: "abc"
        abc_msg("abc");

        // 2: 128 bytes, pad block carries 0x80 at word 0
        for (int i = 0; i < 32; i++) msg_words[i] = $urandom;
        run_msg("m128", 32, 4);
        check("m128_b1_w0", 128'(word_of(blk_at(1), 0)), 128'(32'h80000000));
        check("m128_b1_w31", 128'(word_of(blk_at(1), 31)), 128'(32'h00000800));

        // 3: 112 bytes, marker lands in word 28 and length spills over
        for (int i = 0; i < 28; i++) msg_words[i] = $urandom;
        run_msg("m112", 28, 4);
        check("m112_b0_w28", 128'(word_of(blk_at(0), 28)), 128'(32'h80000000));
        acc_or = word_of(blk_at(0), 29) | word_of(blk_at(0), 30) | word_of(blk_at(0), 31);
        check("m112_b0_w29_31", 128'(acc_or), 128'(0));
        acc_or = '0;
        for (int i = 0; i <= 30; i++) acc_or |= word_of(blk_at(1), i);
        check("m112_b1_w0_30", 128'(acc_or), 128'(0));
        check("m112_b1_w31", 128'(word_of(blk_at(1), 31)), 128'(32'h00000780));

        // 4: empty message; the data word must be masked away
        msg_words[0] = $urandom | 32'h01010101;
        run_msg("empty", 1, 0);
        check("empty_w0", 128'(word_of(blk_at(0), 0)), 128'(32'h80000000));
        check("empty_w31", 128'(word_of(blk_at(0), 31)), 128'(32'h00000400));

        // 5: 40 words with valid held through WAIT
        wait_valid_cycles = 0;
        for (int i = 0; i < 40; i++) msg_words[i] = $urandom;
        run_msg("hold", 40, 2);
        check("hold_saw_wait_valid", 128'(wait_valid_cycles > 0), 128'(1));

        // 6: illegal byte count
        clear_capture();
        msg_words[0] = 32'hdeadbeef;
        send_msg(1, 3'd5);
        wait_idle("bad");
        check("bad_err", 128'(error_o), 128'(1));
        check("bad_ncmd", 128'(blk_q.size()), 128'(0));
        check("bad_done", 128'(done_cnt), 128'(0));

        // start after an error clears it
        abc_msg("abc_after_err");

        // reset while waiting on the core
        core_lat = 40;
        clear_capture();
        for (int i = 0; i < 5; i++) msg_words[i] = $urandom;
        send_msg(5, 3'd4);
        g = 0;
        while (state_o != ST_WAIT && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("rstw_reached_wait", 128'(g < 50), 128'(1));
        #3 reset_n = 1'b0;
        #1;
        check("rstw_init", 128'(core_init_o), 128'(0));
        check("rstw_next", 128'(core_next_o), 128'(0));
        check("rstw_busy", 128'(busy_o), 128'(0));
        check("rstw_done", 128'(done_o), 128'(0));
        check("rstw_ready", 128'(msg_if.msg_ready_o), 128'(0));
        check_blk("rstw_block", core_block_o, '0);
        @(negedge clk);
        reset_n  = 1'b1;
        core_lat = 3;
        @(negedge clk);
        abc_msg("abc_after_rst");

        check("no_init_next_overlap", 128'(both_viol), 128'(0));
        check("no_ready_in_wait", 128'(ready_viol), 128'(0));
        check("block_stable_in_wait", 128'(stab_viol), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
